uart_rx_param: RTL and testbench

//  Parametrised next-generation UART receiver. Deserialises async serial SI using an

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync.sv | 25 ++
 rtl/uart_rx_param.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the rx and tx sides.
//   - Parity mode encodings as carried on PARITY_MODE (2'b11 also means none).
//   - Receiver state encoding.
//   - maj3: 2-of-3 majority used by the oversampling vote.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Metastability synchroniser for an asynchronous level input.
// The chain resets to 1 because the lines it serves (serial data, CTS) idle high.
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_d      asynchronous input
//   o_q      synchronised output, STAGES clocks of latency
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_chain <= '1;
    else          r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampled majority-vote sampling, optional
// parity, one or two stop bits, break detection and a valid/ready holding register.
//   CLOCK_RX     clock, rising edge
//   NRESET       asynchronous active-low reset
//   SI           serial input, idle high
//   S_TICK       oversample enable, OS ticks per bit
//   PARITY_MODE  00/11 none, 01 even, 10 odd (latched at start of frame)
//   STOP2        check a second stop bit (latched at start of frame)
//   RX_DATA      received word, held while RX_VALID
//   RX_VALID     word available; RX_READY accepts it
//   FRAME_ERR    stop bit sampled 0 (qualified by RX_VALID)
//   PARITY_ERR   parity mismatch (qualified by RX_VALID)
//   BREAK_DET    break frame (qualified by RX_VALID)
//   OVERRUN      sticky: a completed word was dropped; cleared by handshake
//   NINTI        active-low interrupt, ~RX_VALID
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OS          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLOCK_RX,
  input  logic                 NRESET,
  input  logic                 SI,
  input  logic                 S_TICK,
  input  logic [1:0]           PARITY_MODE,
  input  logic                 STOP2,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 BREAK_DET,
  output logic                 OVERRUN,
  output logic                 NINTI
);

  localparam int TW = $clog2(OS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic w_si_s;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (CLOCK_RX),
    .i_rst_n (NRESET),
    .i_d     (SI),
    .o_q     (w_si_s)
  );

  // Frame FSM state
  rx_state_e            r_state, w_state_n;
  logic [TW-1:0]        r_tick, w_tick_n;
  logic [BW-1:0]        r_bit, w_bit_n;
  logic                 r_stop_idx, w_stop_idx_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_par_bit, w_par_bit_n;
  logic                 r_fe_acc, w_fe_acc_n;
  logic [1:0]           r_mode, w_mode_n;
  logic                 r_stop2, w_stop2_n;
  logic [2:0]           r_vote;

  // Completion outputs of the FSM (combinational, valid with w_done)
  logic w_done, w_fe, w_brk;
  logic w_bit, w_mid, w_end, w_par_en, w_pe;

  // Completion capture stage and holding register
  logic                 r_done_p1, r_fe_p1, r_pe_p1, r_brk_p1;
  logic [DATA_BITS-1:0] r_data_p1;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_fe, r_pe, r_brk, r_ovr;
  logic                 w_hs;

  // The decision uses the three samples taken on the ticks before the sample tick.
  assign w_bit    = maj3(r_vote);
  assign w_mid    = (r_tick == TICK_MID);
  assign w_end    = (r_tick == TICK_LAST);
  assign w_par_en = (r_mode == PAR_EVEN) || (r_mode == PAR_ODD);
  assign w_pe     = w_par_en & ((^r_shift ^ r_par_bit) != (r_mode == PAR_ODD));

  always_ff @(posedge CLOCK_RX or negedge NRESET) begin
    if (!NRESET) begin
      r_state    <= ST_IDLE;
      r_tick     <= '0;
      r_bit      <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_fe_acc   <= 1'b0;
      r_mode     <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_vote     <= 3'b111;
    end else begin
      r_state    <= w_state_n;
      r_tick     <= w_tick_n;
      r_bit      <= w_bit_n;
      r_stop_idx <= w_stop_idx_n;
      r_shift    <= w_shift_n;
      r_par_bit  <= w_par_bit_n;
      r_fe_acc   <= w_fe_acc_n;
      r_mode     <= w_mode_n;
      r_stop2    <= w_stop2_n;
      if (S_TICK) r_vote <= {r_vote[1:0], w_si_s};
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_tick_n     = r_tick;
    w_bit_n      = r_bit;
    w_stop_idx_n = r_stop_idx;
    w_shift_n    = r_shift;
    w_par_bit_n  = r_par_bit;
    w_fe_acc_n   = r_fe_acc;
    w_mode_n     = r_mode;
    w_stop2_n    = r_stop2;
    w_done       = 1'b0;
    w_fe         = 1'b0;
    w_brk        = 1'b0;

    if (S_TICK) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_si_s) begin
            w_state_n = ST_START;
            w_tick_n  = '0;
            w_mode_n  = PARITY_MODE;
            w_stop2_n = STOP2;
          end
        end

        ST_START: begin
          if (w_mid) begin
            // A start bit that is high again at mid-bit was a glitch.
            w_state_n   = w_bit ? ST_IDLE : ST_DATA;
            w_tick_n    = '0;
            w_bit_n     = '0;
            w_par_bit_n = 1'b0;
            w_fe_acc_n  = 1'b0;
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_end) begin
            w_tick_n  = '0;
            w_shift_n = {w_bit, r_shift[DATA_BITS-1:1]};
            if (r_bit == LAST_BIT) begin
              w_bit_n      = '0;
              w_stop_idx_n = 1'b0;
              w_state_n    = w_par_en ? ST_PARITY : ST_STOP;
            end else begin
              w_bit_n = r_bit + 1'b1;
            end
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end

        ST_PARITY: begin
          if (w_end) begin
            w_tick_n     = '0;
            w_par_bit_n  = w_bit;
            w_stop_idx_n = 1'b0;
            w_state_n    = ST_STOP;
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_end) begin
            w_tick_n = '0;
            if (r_stop2 && !r_stop_idx) begin
              w_stop_idx_n = 1'b1;
              w_fe_acc_n   = r_fe_acc | ~w_bit;
            end else begin
              // Last stop sample closes the frame at mid-bit.
              w_done    = 1'b1;
              w_fe      = r_fe_acc | ~w_bit;
              w_brk     = (r_shift == '0) & (~w_par_en | ~r_par_bit) & ~w_bit;
              w_state_n = w_brk ? ST_BRK_WAIT : ST_IDLE;
            end
          end else begin
            w_tick_n = r_tick + 1'b1;
          end
        end

        ST_BRK_WAIT: begin
          if (w_si_s) w_state_n = ST_IDLE;
        end

        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  // Stage p1: capture the completed word one cycle after the completing tick
  always_ff @(posedge CLOCK_RX or negedge NRESET) begin
    if (!NRESET) begin
      r_done_p1 <= 1'b0;
      r_data_p1 <= '0;
      r_fe_p1   <= 1'b0;
      r_pe_p1   <= 1'b0;
      r_brk_p1  <= 1'b0;
    end else begin
      r_done_p1 <= w_done;
      if (w_done) begin
        r_data_p1 <= r_shift;
        r_fe_p1   <= w_fe;
        r_pe_p1   <= w_pe;
        r_brk_p1  <= w_brk;
      end
    end
  end

  assign w_hs = r_rx_valid & RX_READY;

  // Holding register: a word completing while the previous one is still
  // unaccepted is dropped; a same-cycle handshake frees the slot for it.
  always_ff @(posedge CLOCK_RX or negedge NRESET) begin
    if (!NRESET) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_fe       <= 1'b0;
      r_pe       <= 1'b0;
      r_brk      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (w_hs) r_ovr <= 1'b0;
      if (r_done_p1 && r_rx_valid && !w_hs) r_ovr <= 1'b1;

      if (r_done_p1 && (!r_rx_valid || w_hs)) begin
        r_rx_data  <= r_data_p1;
        r_fe       <= r_fe_p1;
        r_pe       <= r_pe_p1;
        r_brk      <= r_brk_p1;
        r_rx_valid <= 1'b1;
      end else if (w_hs) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign RX_DATA    = r_rx_data;
  assign RX_VALID   = r_rx_valid;
  assign FRAME_ERR  = r_fe;
  assign PARITY_ERR = r_pe;
  assign BREAK_DET  = r_brk;
  assign OVERRUN    = r_ovr;
  assign NINTI      = ~r_rx_valid;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  logic       CLOCK_RX = 1'b0;
  logic       NRESET;
  logic       SI;
  logic       S_TICK;
  logic [1:0] PARITY_MODE;
  logic       STOP2;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       FRAME_ERR;
  logic       PARITY_ERR;
  logic       BREAK_DET;
  logic       OVERRUN;
  logic       NINTI;

  int checks = 0;
  int errors = 0;

  uart_rx_param #(
    .DATA_BITS   (8),
    .OS          (16),
    .SYNC_STAGES (2)
  ) dut (
    .CLOCK_RX    (CLOCK_RX),
    .NRESET      (NRESET),
    .SI          (SI),
    .S_TICK      (S_TICK),
    .PARITY_MODE (PARITY_MODE),
    .STOP2       (STOP2),
    .RX_DATA     (RX_DATA),
    .RX_VALID    (RX_VALID),
    .RX_READY    (RX_READY),
    .FRAME_ERR   (FRAME_ERR),
    .PARITY_ERR  (PARITY_ERR),
    .BREAK_DET   (BREAK_DET),
    .OVERRUN     (OVERRUN),
    .NINTI       (NINTI)
  );

  always #5 CLOCK_RX = ~CLOCK_RX;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       brk;
  } word_t;

  word_t mon_q[$];

  // Every accepted word is recorded.
  always @(negedge CLOCK_RX) begin
    if (NRESET && RX_VALID && RX_READY)
      mon_q.push_back({RX_DATA, FRAME_ERR, PARITY_ERR, BREAK_DET});
  end

  typedef struct {
    logic [7:0] d;
    logic [1:0] mode;
    logic       s2;
    logic       pb;
    logic [1:0] sb;   // sb[0] first stop, sb[1] second stop
    int         gb;   // data bit carrying a one-tick glitch, -1 none
    int         gp;   // tick position of the glitch inside that bit
    bit         lat;  // check RX_VALID timing around the last stop sample
    logic [7:0] ed;
    logic       efe;
    logic       epe;
    logic       ebrk;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One oversample tick every 4 clocks; returns on the negedge after the tick.
  task automatic do_tick();
    repeat (3) @(negedge CLOCK_RX);
    S_TICK = 1'b1;
    @(negedge CLOCK_RX);
    S_TICK = 1'b0;
  endtask

  task automatic send_bit(input logic v, input int gp, input int n);
    for (int t = 0; t < n; t++) begin
      SI = (t == gp) ? ~v : v;
      do_tick();
    end
  endtask

  task automatic idle_ticks(input int n);
    SI = 1'b1;
    repeat (n) do_tick();
  endtask

  // The last stop bit is driven only up to its mid-bit sample, then the line idles.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic s2,
                            input logic pb, input logic [1:0] sb, input int gb, input int gp,
                            input bit lat);
    logic last;
    PARITY_MODE = mode;
    STOP2       = s2;
    send_bit(1'b0, -1, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == gb) ? gp : -1, 16);
    if (mode == 2'b01 || mode == 2'b10) send_bit(pb, -1, 16);
    if (s2) send_bit(sb[0], -1, 16);
    last = s2 ? sb[1] : sb[0];
    send_bit(last, -1, 9);
    if (lat) begin
      chk("valid_before_load", 32'(RX_VALID), 32'd0);
      @(negedge CLOCK_RX);
      chk("valid_one_cycle_after", 32'(RX_VALID), 32'd1);
      chk("ninti_low", 32'(NINTI), 32'd0);
    end
    idle_ticks(12);
  endtask

  task automatic check_word(input string nm, input logic [7:0] ed, input logic efe,
                            input logic epe, input logic ebrk);
    word_t w;
    chk({nm, "_count"}, 32'(mon_q.size()), 32'd1);
    if (mon_q.size() > 0) begin
      w = mon_q.pop_front();
      chk({nm, "_data"}, 32'(w.d), 32'(ed));
      chk({nm, "_fe"}, 32'(w.fe), 32'(efe));
      chk({nm, "_pe"}, 32'(w.pe), 32'(epe));
      chk({nm, "_brk"}, 32'(w.brk), 32'(ebrk));
    end
    mon_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] mode;
    logic       s2, pe_en, flip, pb, last, efe, ebrk;
    logic [1:0] sb;
    int         gb, gp;

    //              d      mode   s2    pb    sb     gb  gp lat  ed     fe    pe    brk
    tbl[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0, 1, 8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 2'b01, 1'b0, 1'b1, 2'b11, -1, 0, 0, 8'h3C, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 2'b01, 1'b0, 1'b0, 2'b11, -1, 0, 0, 8'h3C, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h0F, 2'b00, 1'b0, 1'b0, 2'b11,  2, 6, 0, 8'h0F, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h96, 2'b10, 1'b0, 1'b1, 2'b11, -1, 0, 0, 8'h96, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h81, 2'b00, 1'b1, 1'b0, 2'b01, -1, 0, 0, 8'h81, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{8'h00, 2'b01, 1'b0, 1'b0, 2'b00, -1, 0, 0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{8'h7E, 2'b11, 1'b1, 1'b0, 2'b10,  5, 7, 0, 8'h7E, 1'b1, 1'b0, 1'b0};

    NRESET      = 1'b0;
    SI          = 1'b1;
    S_TICK      = 1'b0;
    PARITY_MODE = 2'b00;
    STOP2       = 1'b0;
    RX_READY    = 1'b1;
    repeat (4) @(negedge CLOCK_RX);
    chk("rst_valid", 32'(RX_VALID), 32'd0);
    chk("rst_data", 32'(RX_DATA), 32'd0);
    chk("rst_flags", 32'({FRAME_ERR, PARITY_ERR, BREAK_DET}), 32'd0);
    chk("rst_overrun", 32'(OVERRUN), 32'd0);
    chk("rst_ninti", 32'(NINTI), 32'd1);
    NRESET = 1'b1;
    idle_ticks(8);

    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i].d, tbl[i].mode, tbl[i].s2, tbl[i].pb, tbl[i].sb,
                 tbl[i].gb, tbl[i].gp, tbl[i].lat);
      check_word($sformatf("vec%0d", i), tbl[i].ed, tbl[i].efe, tbl[i].epe, tbl[i].ebrk);
    end

    // Short low pulse on an idle line is rejected as a false start.
    PARITY_MODE = 2'b00;
    STOP2 = 1'b0;
    send_bit(1'b0, -1, 4);
    idle_ticks(40);
    chk("glitch_start_words", 32'(mon_q.size()), 32'd0);
    chk("glitch_start_valid", 32'(RX_VALID), 32'd0);
    mon_q.delete();

    // Line held low for 20 bit times: one break word, then nothing until high.
    SI = 1'b0;
    repeat (320) do_tick();
    idle_ticks(30);
    check_word("break", 8'h00, 1'b1, 1'b0, 1'b1);

    // Randomised frames against the frame-level model.
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = 8'h00;
      mode  = 2'($urandom_range(0, 3));
      s2    = ($urandom_range(0, 1) == 1);
      pe_en = (mode == 2'b01) || (mode == 2'b10);
      flip  = ($urandom_range(0, 3) == 0);
      pb    = (^d) ^ (mode == 2'b10) ^ flip;
      sb[0] = ($urandom_range(0, 4) != 0);
      sb[1] = ($urandom_range(0, 4) != 0);
      gb    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      gp    = int'($urandom_range(0, 15));
      last  = s2 ? sb[1] : sb[0];
      efe   = ~sb[0] | (s2 & ~sb[1]);
      ebrk  = (d == 8'h00) && (!pe_en || pb == 1'b0) && (last == 1'b0);
      send_frame(d, mode, s2, pb, sb, gb, gp, 0);
      check_word($sformatf("rnd%0d", n), d, efe, pe_en & flip, ebrk);
    end

    // Overrun: second word dropped while the first is unaccepted.
    RX_READY = 1'b0;
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0, 0);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0, 0);
    chk("ovr_valid", 32'(RX_VALID), 32'd1);
    chk("ovr_data", 32'(RX_DATA), 32'h11);
    chk("ovr_flag", 32'(OVERRUN), 32'd1);
    chk("ovr_ninti", 32'(NINTI), 32'd0);
    @(negedge CLOCK_RX);
    RX_READY = 1'b1;
    @(negedge CLOCK_RX);
    RX_READY = 1'b0;
    @(negedge CLOCK_RX);
    chk("hs_valid", 32'(RX_VALID), 32'd0);
    chk("hs_overrun", 32'(OVERRUN), 32'd0);
    chk("hs_ninti", 32'(NINTI), 32'd1);
    RX_READY = 1'b1;
    mon_q.delete();

    // Reset in the middle of the data bits aborts the frame.
    PARITY_MODE = 2'b00;
    STOP2 = 1'b0;
    send_bit(1'b0, -1, 16);
    send_bit(1'b1, -1, 16);
    send_bit(1'b0, -1, 16);
    send_bit(1'b1, -1, 8);
    NRESET = 1'b0;
    SI = 1'b1;
    @(negedge CLOCK_RX);
    chk("midrst_data", 32'(RX_DATA), 32'd0);
    chk("midrst_valid", 32'(RX_VALID), 32'd0);
    chk("midrst_ninti", 32'(NINTI), 32'd1);
    @(negedge CLOCK_RX);
    NRESET = 1'b1;
    idle_ticks(40);
    chk("midrst_nowords", 32'(mon_q.size()), 32'd0);
    mon_q.delete();
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 2'b11, -1, 0, 0);
    check_word("after_rst", 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
